// File: rtl/triangle_classifier_pipe.sv
// triangle_classifier_pipe: three-stage valid/ready pipeline that classifies side triples as triangles
// Ports:
//   clk_i, rst_ni            clock (rising edge), asynchronous active-low reset
//   in_valid_i, in_ready_o   input handshake for the a_i/b_i/c_i side triple
//   a_i, b_i, c_i            unsigned side lengths, WIDTH bits
//   out_valid_o, out_ready_i output handshake
//   out_o                    1 = non-degenerate triangle
//   kind_o                   0 none, 1 equilateral, 2 isosceles, 3 scalene, 4 right
//   cnt_clr_i                synchronous clear of both statistics counters
//   cnt_total_o, cnt_tri_o   saturating counts of delivered results / delivered triangles
module triangle_classifier_pipe #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16,
  parameter bit RIGHT_EN  = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic [WIDTH-1:0]     c_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 out_o,
  output logic [2:0]           kind_o,
  input  logic                 cnt_clr_i,
  output logic [CNT_WIDTH-1:0] cnt_total_o,
  output logic [CNT_WIDTH-1:0] cnt_tri_o
);
  localparam int SW = 2 * WIDTH + 1;
  logic                 en;
  logic [WIDTH-1:0]     p, q, lo_d, mid_d, hi_d;
  logic                 v1_q;
  logic [WIDTH-1:0]     lo1_q, mid1_q, hi1_q;
  logic [WIDTH:0]       sum_d;
  logic [2*WIDTH-1:0]   lo_sq, mid_sq, hi_sq;
  logic [SW-1:0]        sumsq_d;
  logic                 v2_q, eq_lm2_q, eq_mh2_q, lo_nz2_q;
  logic [WIDTH:0]       sum2_q;
  logic [WIDTH-1:0]     hi2_q;
  logic [SW-1:0]        sumsq2_q, hisq2_q;
  logic                 tri_d;
  logic [2:0]           kind_d;
  logic                 v3_q, out_q;
  logic [2:0]           kind_q;
  logic [CNT_WIDTH-1:0] total_q, tri_q;
  logic                 fire;
  // One global advance: every stage moves only when the output slot is free or being drained.
  assign en          = ~v3_q | out_ready_i;
  assign in_ready_o  = en;
  assign out_valid_o = v3_q;
  assign out_o       = out_q;
  assign kind_o      = kind_q;
  assign cnt_total_o = total_q;
  assign cnt_tri_o   = tri_q;
  assign fire        = v3_q & out_ready_i;
  // Three-element sort: order a/b, then slot c around that pair.
  always_comb begin
    p     = (a_i < b_i) ? a_i : b_i;
    q     = (a_i < b_i) ? b_i : a_i;
    lo_d  = (c_i < p) ? c_i : p;
    hi_d  = (c_i > q) ? c_i : q;
    mid_d = (c_i < p) ? p : ((c_i > q) ? q : c_i);
  end
  always_comb begin
    sum_d   = {1'b0, lo1_q} + {1'b0, mid1_q};
    lo_sq   = {{WIDTH{1'b0}}, lo1_q} * {{WIDTH{1'b0}}, lo1_q};
    mid_sq  = {{WIDTH{1'b0}}, mid1_q} * {{WIDTH{1'b0}}, mid1_q};
    hi_sq   = {{WIDTH{1'b0}}, hi1_q} * {{WIDTH{1'b0}}, hi1_q};
    sumsq_d = {1'b0, lo_sq} + {1'b0, mid_sq};
  end
  // Sorted sides make lo==hi equivalent to all three equal.
  always_comb begin
    tri_d  = (sum2_q > {1'b0, hi2_q}) & lo_nz2_q;
    kind_d = !tri_d                        ? 3'd0 :
             (eq_lm2_q & eq_mh2_q)         ? 3'd1 :
             (RIGHT_EN && sumsq2_q == hisq2_q) ? 3'd4 :
             (eq_lm2_q | eq_mh2_q)         ? 3'd2 : 3'd3;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q     <= 1'b0;
      lo1_q    <= '0;
      mid1_q   <= '0;
      hi1_q    <= '0;
      v2_q     <= 1'b0;
      sum2_q   <= '0;
      hi2_q    <= '0;
      sumsq2_q <= '0;
      hisq2_q  <= '0;
      eq_lm2_q <= 1'b0;
      eq_mh2_q <= 1'b0;
      lo_nz2_q <= 1'b0;
      v3_q     <= 1'b0;
      out_q    <= 1'b0;
      kind_q   <= 3'd0;
    end else if (en) begin
      v1_q     <= in_valid_i;
      lo1_q    <= lo_d;
      mid1_q   <= mid_d;
      hi1_q    <= hi_d;
      v2_q     <= v1_q;
      sum2_q   <= sum_d;
      hi2_q    <= hi1_q;
      sumsq2_q <= sumsq_d;
      hisq2_q  <= {1'b0, hi_sq};
      eq_lm2_q <= lo1_q == mid1_q;
      eq_mh2_q <= mid1_q == hi1_q;
      lo_nz2_q <= lo1_q != '0;
      v3_q     <= v2_q;
      out_q    <= tri_d;
      kind_q   <= kind_d;
    end
  end
  // Clear wins over a same-cycle delivery; counts stick at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      total_q <= '0;
      tri_q   <= '0;
    end else begin
      total_q <= cnt_clr_i ? '0 : (fire && ~&total_q) ? total_q + CNT_WIDTH'(1) : total_q;
      tri_q   <= cnt_clr_i ? '0 : (fire && out_q && ~&tri_q) ? tri_q + CNT_WIDTH'(1) : tri_q;
    end
  end
endmodule

// File: tb/tb_triangle_classifier_pipe.sv
// tb_triangle_classifier_pipe: scoreboard bench driving three parameterisations of the classifier in lockstep
module tb_triangle_classifier_pipe;
  typedef struct packed {
    int             acc;
    logic [2:0][3:0] e;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1, cnt_clr = 1'b0;
  logic [11:0] a = '0, b = '0, c = '0;
  logic rnd = 1'b0, chk_lat = 1'b0;
  int cyc = 0, n_chk = 0, n_pass = 0;
  exp_t q[$];
  logic ir[3], ov[3];
  logic [3:0] rs[3], hv[3];
  logic [15:0] ct[3], cr[3];
  int mt[3], mr[3];
  int maxc[3] = '{65535, 15, 65535};
  bit held = 1'b0;
  logic o0, o1, o2;
  logic [2:0] k0, k1, k2;
  logic [15:0] t0, r0, t2, r2;
  logic [3:0] t1, r1;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  triangle_classifier_pipe #(.WIDTH(8), .CNT_WIDTH(16), .RIGHT_EN(1'b1)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(ir[0]),
    .a_i(a[7:0]), .b_i(b[7:0]), .c_i(c[7:0]), .out_valid_o(ov[0]), .out_ready_i(out_ready),
    .out_o(o0), .kind_o(k0), .cnt_clr_i(cnt_clr), .cnt_total_o(t0), .cnt_tri_o(r0));
  triangle_classifier_pipe #(.WIDTH(8), .CNT_WIDTH(4), .RIGHT_EN(1'b0)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(ir[1]),
    .a_i(a[7:0]), .b_i(b[7:0]), .c_i(c[7:0]), .out_valid_o(ov[1]), .out_ready_i(out_ready),
    .out_o(o1), .kind_o(k1), .cnt_clr_i(cnt_clr), .cnt_total_o(t1), .cnt_tri_o(r1));
  triangle_classifier_pipe #(.WIDTH(12), .CNT_WIDTH(16), .RIGHT_EN(1'b1)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(ir[2]),
    .a_i(a), .b_i(b), .c_i(c), .out_valid_o(ov[2]), .out_ready_i(out_ready),
    .out_o(o2), .kind_o(k2), .cnt_clr_i(cnt_clr), .cnt_total_o(t2), .cnt_tri_o(r2));
  assign rs[0] = {o0, k0};
  assign rs[1] = {o1, k1};
  assign rs[2] = {o2, k2};
  assign ct[0] = t0;
  assign cr[0] = r0;
  assign ct[1] = {12'd0, t1};
  assign cr[1] = {12'd0, r1};
  assign ct[2] = t2;
  assign cr[2] = r2;
  function automatic void chk(string nm, int i, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s[u%0d] at cycle %0d: got %0d, expected %0d", nm, i, cyc, act, exp);
  endfunction
  // Reference classifier straight from the triangle rules: {is_triangle, kind}.
  function automatic logic [3:0] model(int x, int y, int z, int w, bit re);
    longint m = (64'd1 << w) - 1;
    longint s0 = x & m, s1 = y & m, s2 = z & m;
    longint lo, hi, mid;
    lo  = s0 < s1 ? (s0 < s2 ? s0 : s2) : (s1 < s2 ? s1 : s2);
    hi  = s0 > s1 ? (s0 > s2 ? s0 : s2) : (s1 > s2 ? s1 : s2);
    mid = s0 + s1 + s2 - lo - hi;
    if (!(lo + mid > hi && lo != 0)) return 4'd0;
    if (s0 == s1 && s1 == s2) return 4'h9;
    if (re && lo * lo + mid * mid == hi * hi) return 4'hc;
    if (s0 == s1 || s1 == s2 || s0 == s2) return 4'ha;
    return 4'hb;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        chk("rst_out_valid", i, ov[i], 0);
        chk("rst_cnt_total", i, ct[i], 0);
        chk("rst_cnt_tri", i, cr[i], 0);
        mt[i] = 0;
        mr[i] = 0;
      end
      q.delete();
      held = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        chk("cnt_total", i, ct[i], mt[i]);
        chk("cnt_tri", i, cr[i], mr[i]);
        if (held) begin
          chk("hold_valid", i, ov[i], 1);
          chk("hold_result", i, rs[i], hv[i]);
        end
      end
      if (ov[0] && out_ready) begin
        if (q.size() == 0) chk("spurious_result", 0, 1, 0);
        else begin
          e = q.pop_front();
          for (int i = 0; i < 3; i++) begin
            chk("valid_lockstep", i, ov[i], 1);
            chk("result", i, rs[i], e.e[i]);
          end
          if (chk_lat) chk("latency", 0, cyc - e.acc, 2);
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (cnt_clr) begin
          mt[i] = 0;
          mr[i] = 0;
        end else if (ov[0] && out_ready) begin
          mt[i] = mt[i] < maxc[i] ? mt[i] + 1 : mt[i];
          mr[i] = (rs[i][3] && mr[i] < maxc[i]) ? mr[i] + 1 : mr[i];
        end
        hv[i] = rs[i];
      end
      held = ov[0] && !out_ready;
    end
  end
  function automatic logic pick_ready();
    return rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction
  task automatic send(input int x, input int y, input int z, input bit clr = 1'b0);
    exp_t e;
    int t = 0;
    @(negedge clk);
    out_ready = pick_ready();
    a = 12'(x);
    b = 12'(y);
    c = 12'(z);
    in_valid = 1'b1;
    cnt_clr = clr;
    #1;
    while (!ir[0]) begin
      if (++t > 200) begin
        $display("FAIL accept_timeout: in_ready stuck at 0, expected 1 within 200 cycles");
        $fatal(1);
      end
      @(negedge clk);
      out_ready = pick_ready();
      #1;
    end
    e.acc = cyc + 1;
    e.e[0] = model(x, y, z, 8, 1'b1);
    e.e[1] = model(x, y, z, 8, 1'b0);
    e.e[2] = model(x, y, z, 12, 1'b1);
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cnt_clr = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      out_ready = pick_ready();
      in_valid = 1'b0;
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    cnt_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic drain();
    int t = 0;
    rnd = 1'b0;
    while (q.size() != 0 && t < 50) begin
      idle(1);
      t++;
    end
    idle(2);
    chk("drain_empty", 0, q.size(), 0);
  endtask
  initial begin
    int x, y, z;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) chk("reset_in_ready", i, ir[i], 1);
    chk_lat = 1'b1;
    send(3, 4, 5); send(1, 1, 1); send(10, 100, 255); send(127, 255, 200);
    drain();
    send(1, 128, 127); send(254, 127, 127); send(127, 127, 254); send(255, 255, 255); send(0, 5, 5);
    drain();
    send(5, 12, 13); send(2000, 1500, 2500); send(5, 5, 8); send(8, 5, 5);
    drain();
    chk_lat = 1'b0;
    rnd = 1'b1;
    for (int n = 0; n < 20; n++) begin
      x = $urandom_range(1, 255);
      y = $urandom_range(0, 3) == 0 ? x : $urandom_range(1, 255);
      z = $urandom_range(0, 4) == 0 ? y : $urandom_range(0, 255);
      send(x, y, z);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();
    chk_lat = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    for (int n = 0; n < 20; n++) send(3, 4, 5);
    send(6, 8, 10, 1'b1);
    drain();
    send(3, 4, 5); send(7, 7, 7); send(2, 3, 4);
    do_reset();
    send(3, 4, 5);
    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
